// File: rtl/io_port_controller.sv
// I/O port controller: blocking switch-input capture with a confirm strobe, plus channelled output registers.
// Define IO_TIMEOUT_EN to bound the wait for the confirm strobe to TIMEOUT_CYC cycles.
module io_port_controller #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned SW_W        = 13,
    parameter int unsigned N_OUT       = 2,
    parameter int unsigned PORT_W      = 3,
    parameter int unsigned SIGN_EXT    = 1,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    Req,
    input  logic                    Dir,
    input  logic [PORT_W-1:0]       Port,
    input  logic [DATA_W-1:0]       WrData,
    input  logic [SW_W-1:0]         Switches,
    input  logic                    Set,
    input  logic                    Halt,
    output logic [DATA_W-1:0]       DataIO,
    output logic [N_OUT*DATA_W-1:0] Output,
    output logic                    BlockSystem,
    output logic                    InValid,
    output logic                    Halted,
    output logic                    Timeout
);

    // Elaboration-time parameter sanity checks
    if (SW_W == 0 || SW_W > DATA_W) begin : g_bad_sw_w
        $error("io_port_controller: SW_W must be in 1..DATA_W");
    end
    if (N_OUT < 1 || N_OUT > 8) begin : g_bad_n_out
        $error("io_port_controller: N_OUT must be in 1..8");
    end
    if (PORT_W < 1) begin : g_bad_port_w
        $error("io_port_controller: PORT_W must be at least 1");
    end
    if (TIMEOUT_CYC < 1) begin : g_bad_timeout
        $error("io_port_controller: TIMEOUT_CYC must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_SET = 2'd1,
        CAPTURE  = 2'd2,
        HALTED   = 2'd3
    } state_t;

    state_t                       state;
    state_t                       next_state;
    logic                         set_d;
    logic                         set_edge;
    logic                         cap_load;
    logic                         cap_timeout;
    logic                         wr_req;
    logic                         expired;
    logic [DATA_W-1:0]            sw_ext;
    logic [N_OUT-1:0]             ch_we;
    logic [N_OUT-1:0][DATA_W-1:0] out_q;

    assign set_edge = Set & ~set_d;

    // Widen the switch value to the CPU word
    if (SIGN_EXT != 0) begin : g_sext
        assign sw_ext = DATA_W'($signed(Switches));
    end else begin : g_zext
        assign sw_ext = DATA_W'(Switches);
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
            set_d <= 1'b0;
        end else begin
            state <= next_state;
            set_d <= Set;
        end
    end

    // Halt overrides everything; CAPTURE ignores Req so a held input instruction cannot retrigger
    always_comb begin
        next_state  = state;
        cap_load    = 1'b0;
        cap_timeout = 1'b0;
        wr_req      = 1'b0;
        if (Halt) begin
            next_state = HALTED;
        end else begin
            case (state)
                IDLE: begin
                    if (Req) begin
                        if (Dir) begin
                            wr_req = 1'b1;
                        end else begin
                            next_state = WAIT_SET;
                        end
                    end
                end
                WAIT_SET: begin
                    if (set_edge) begin
                        cap_load   = 1'b1;
                        next_state = CAPTURE;
                    end else if (expired) begin
                        cap_timeout = 1'b1;
                        next_state  = CAPTURE;
                    end
                end
                CAPTURE: next_state = IDLE;
                HALTED:  next_state = HALTED;
                default: next_state = IDLE;
            endcase
        end
    end

    assign BlockSystem = (state == WAIT_SET) || (state == HALTED) ||
                         ((state == IDLE) && Req && !Dir) || Halt;
    assign InValid     = (state == CAPTURE);
    assign Halted      = (state == HALTED);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            DataIO <= '0;
        end else if (cap_load) begin
            DataIO <= sw_ext;
        end else if (cap_timeout) begin
            DataIO <= '0;
        end
    end

    // Out-of-range Port values match no channel, so the write is dropped
    always_comb begin
        ch_we = '0;
        for (int k = 0; k < int'(N_OUT); k++) begin
            ch_we[k] = wr_req && (32'(Port) == 32'(k));
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            out_q <= '0;
        end else begin
            for (int k = 0; k < int'(N_OUT); k++) begin
                if (ch_we[k]) begin
                    out_q[k] <= WrData;
                end
            end
        end
    end

    assign Output = out_q;

`ifdef IO_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_q;

    // Counter sits at zero outside WAIT_SET, so it is clear on every entry
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            wait_cnt <= '0;
        end else if (state != WAIT_SET) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

    assign expired = (wait_cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            timeout_q <= 1'b0;
        end else if (cap_load) begin
            timeout_q <= 1'b0;
        end else if (cap_timeout) begin
            timeout_q <= 1'b1;
        end
    end

    assign Timeout = timeout_q;
`else
    assign expired = 1'b0;
    assign Timeout = 1'b0;
`endif

endmodule

// File: tb/tb_io_port_controller.sv
// Directed self-checking bench for io_port_controller (sign- and zero-extending instances side by side).
module tb_io_port_controller;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SW_W   = 13;
    localparam int unsigned N_OUT  = 2;
    localparam int unsigned PORT_W = 3;
    localparam int unsigned TO_CYC = 8;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    req;
    logic                    dir;
    logic [PORT_W-1:0]       port;
    logic [DATA_W-1:0]       wr_data;
    logic [SW_W-1:0]         sw;
    logic                    set;
    logic                    halt;

    logic [DATA_W-1:0]       data_io,    data_io_zx;
    logic [N_OUT*DATA_W-1:0] out_bus,    out_bus_zx;
    logic                    blk,        blk_zx;
    logic                    in_valid,   in_valid_zx;
    logic                    halted,     halted_zx;
    logic                    tmo,        tmo_zx;

    int n_chk  = 0;
    int n_pass = 0;
    int blk_cnt;
    logic early;

    always #5 clk = ~clk;

    io_port_controller #(
        .DATA_W(DATA_W), .SW_W(SW_W), .N_OUT(N_OUT), .PORT_W(PORT_W),
        .SIGN_EXT(1), .TIMEOUT_CYC(TO_CYC)
    ) u_dut (
        .Clock(clk), .Reset(rst_n), .Req(req), .Dir(dir), .Port(port),
        .WrData(wr_data), .Switches(sw), .Set(set), .Halt(halt),
        .DataIO(data_io), .Output(out_bus), .BlockSystem(blk),
        .InValid(in_valid), .Halted(halted), .Timeout(tmo)
    );

    io_port_controller #(
        .DATA_W(DATA_W), .SW_W(SW_W), .N_OUT(N_OUT), .PORT_W(PORT_W),
        .SIGN_EXT(0), .TIMEOUT_CYC(TO_CYC)
    ) u_dut_zx (
        .Clock(clk), .Reset(rst_n), .Req(req), .Dir(dir), .Port(port),
        .WrData(wr_data), .Switches(sw), .Set(set), .Halt(halt),
        .DataIO(data_io_zx), .Output(out_bus_zx), .BlockSystem(blk_zx),
        .InValid(in_valid_zx), .Halted(halted_zx), .Timeout(tmo_zx)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic clk_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; dir = 1'b0; port = '0; wr_data = '0;
        sw = '0; set = 1'b0; halt = 1'b0;
        clk_step();
        clk_step();
        check("rst_dataio",   64'(data_io),   64'h0);
        check("rst_output",   64'(out_bus),   64'h0);
        check("rst_block",    64'(blk),       64'h0);
        check("rst_invalid",  64'(in_valid), 64'h0);
        check("rst_halted",   64'(halted),    64'h0);
        check("rst_timeout",  64'(tmo),       64'h0);
        check("rst_zx_state", 64'({blk_zx, halted_zx, tmo_zx}), 64'h0);
        check("rst_zx_out",   64'(out_bus_zx), 64'h0);
        rst_n = 1'b1;
        clk_step();

        // Sign-extended input, confirm edge in the sixth blocked cycle
        sw = 13'h1FFF; req = 1'b1; dir = 1'b0; blk_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (blk) blk_cnt++;
            clk_step();
        end
        set = 1'b1;
        #1;
        if (blk) blk_cnt++;
        clk_step();
        check("sx_invalid",       64'(in_valid),    64'h1);
        check("sx_zx_invalid",    64'(in_valid_zx), 64'h1);
        check("sx_block_capture", 64'(blk),         64'h0);
        check("sx_dataio",        64'(data_io),     64'hFFFF_FFFF);
        check("sx_dataio_zx",     64'(data_io_zx),  64'h0000_1FFF);
        check("sx_block_cycles",  64'(blk_cnt),     64'd6);
        req = 1'b0;
        clk_step();
        check("sx_invalid_drop",  64'(in_valid), 64'h0);
        check("sx_dataio_hold",   64'(data_io),  64'hFFFF_FFFF);

        // Set already high on entry: needs a fresh rising edge
        sw = 13'h1000; req = 1'b1;
        clk_step();
        for (int i = 0; i < 3; i++) clk_step();
        check("held_set_no_capture", 64'(in_valid), 64'h0);
        check("held_set_block",      64'(blk),      64'h1);
        check("held_set_dataio",     64'(data_io),  64'hFFFF_FFFF);
        set = 1'b0;
        clk_step();
        set = 1'b1;
        clk_step();
        check("fresh_edge_invalid", 64'(in_valid),   64'h1);
        check("fresh_edge_dataio",  64'(data_io),    64'hFFFF_F000);
        check("zext_dataio",        64'(data_io_zx), 64'h0000_1000);
        req = 1'b0; set = 1'b0;
        clk_step();

        // Output channel writes
        req = 1'b1; dir = 1'b1; port = 3'd1; wr_data = 32'hCAFE_0001;
        #1;
        check("wr_no_block", 64'(blk), 64'h0);
        clk_step();
        check("wr_ch1", 64'(out_bus), 64'hCAFE_0001_0000_0000);
        port = 3'd0; wr_data = 32'h1234_5678;
        clk_step();
        check("wr_ch0", 64'(out_bus), 64'hCAFE_0001_1234_5678);
        port = 3'd5; wr_data = 32'hDEAD_BEEF;
        clk_step();
        check("wr_port5_ignored", 64'(out_bus), 64'hCAFE_0001_1234_5678);
        port = 3'd2;
        clk_step();
        check("wr_port2_ignored", 64'(out_bus), 64'hCAFE_0001_1234_5678);
        req = 1'b0; port = 3'd0; wr_data = 32'hFFFF_FFFF;
        clk_step();
        check("wr_idle_hold", 64'(out_bus), 64'hCAFE_0001_1234_5678);
        dir = 1'b0;

        // Halt beats a simultaneous confirm edge in WAIT_SET
        sw = 13'h0AAA; req = 1'b1;
        clk_step();
        set = 1'b1; halt = 1'b1;
        clk_step();
        halt = 1'b0; set = 1'b0; req = 1'b0;
        #1;
        check("halt_state",      64'(halted),   64'h1);
        check("halt_no_capture", 64'(in_valid), 64'h0);
        check("halt_dataio",     64'(data_io),  64'hFFFF_F000);
        check("halt_block",      64'(blk),      64'h1);
        req = 1'b1; dir = 1'b1; port = 3'd0; wr_data = 32'h5555_5555; set = 1'b1;
        clk_step();
        clk_step();
        check("halt_sticky",       64'(halted),  64'h1);
        check("halt_block_sticky", 64'(blk),     64'h1);
        check("halt_no_write",     64'(out_bus), 64'hCAFE_0001_1234_5678);
        req = 1'b0; dir = 1'b0; set = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_exit_halted", 64'(halted),  64'h0);
        check("rst_exit_block",  64'(blk),     64'h0);
        check("rst_exit_dataio", 64'(data_io), 64'h0);
        check("rst_exit_output", 64'(out_bus), 64'h0);
        clk_step();
        rst_n = 1'b1;
        clk_step();

        // Halt from IDLE blocks immediately
        halt = 1'b1;
        #1;
        check("halt_idle_block", 64'(blk), 64'h1);
        clk_step();
        halt = 1'b0;
        #1;
        check("halt_from_idle", 64'(halted), 64'h1);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        clk_step();

        // Reset in WAIT_SET abandons the request
        sw = 13'h0777; req = 1'b1;
        clk_step();
        req = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_ws_block", 64'(blk), 64'h0);
        rst_n = 1'b1;
        clk_step();
        set = 1'b1;
        clk_step();
        check("rst_ws_no_capture", 64'(in_valid), 64'h0);
        check("rst_ws_dataio",     64'(data_io),  64'h0);
        set = 1'b0;
        clk_step();

`ifdef IO_TIMEOUT_EN
        sw = 13'h0123; req = 1'b1;
        clk_step();
        set = 1'b1;
        clk_step();
        check("to_pre_dataio", 64'(data_io), 64'h0000_0123);
        check("to_pre_flag",   64'(tmo),     64'h0);
        req = 1'b0; set = 1'b0;
        clk_step();
        req = 1'b1; early = 1'b0;
        clk_step();
        for (int i = 0; i < int'(TO_CYC); i++) begin
            if (in_valid) early = 1'b1;
            clk_step();
        end
        check("to_no_early", 64'(early),    64'h0);
        check("to_invalid",  64'(in_valid), 64'h1);
        check("to_dataio",   64'(data_io),  64'h0);
        check("to_flag",     64'(tmo),      64'h1);
        req = 1'b0;
        clk_step();
        clk_step();
        check("to_flag_sticky", 64'(tmo), 64'h1);
        sw = 13'h0456; req = 1'b1;
        clk_step();
        for (int i = 0; i < int'(TO_CYC) - 1; i++) clk_step();
        set = 1'b1;
        clk_step();
        check("to_edge_wins_invalid", 64'(in_valid), 64'h1);
        check("to_edge_wins_dataio",  64'(data_io),  64'h0000_0456);
        check("to_flag_cleared",      64'(tmo),      64'h0);
        req = 1'b0; set = 1'b0;
        clk_step();
`else
        sw = 13'h0456; req = 1'b1;
        clk_step();
        for (int i = 0; i < 20; i++) clk_step();
        check("wait_forever_invalid", 64'(in_valid), 64'h0);
        check("wait_forever_block",   64'(blk),      64'h1);
        check("wait_forever_timeout", 64'(tmo),      64'h0);
        set = 1'b1;
        clk_step();
        check("late_edge_invalid", 64'(in_valid), 64'h1);
        check("late_edge_dataio",  64'(data_io),  64'h0000_0456);
        check("late_edge_timeout", 64'(tmo),      64'h0);
        req = 1'b0; set = 1'b0;
        clk_step();
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
